ma_stage: RTL
=============

// Module: ma_stage
// PURPOSE
// Memory-access stage: consumes the EX/MA register outputs, resolves conditional branches and
// performs loads/stores on a req/ack data-memory port. It produces write-back data for the
// MA/WB register. It stalls the upstream pipeline while a memory access is outstanding.
// PARAMETERS
// TIMEOUT  16  max cycles in WAIT before bus error (>=2)
// CNT_W    8   width of wait counter (2^CNT_W > TIMEOUT)
// PORTS
// clkIn            in   1   clock, rising edge
// resetIn          in   1   synchronous, active-high reset
// ctrSignalsIn     in   8   [0]MemRead [1]MemWrite [2]RegWrite [3]BrEq [4]BrLt [5]Link [7:6]size 00=W 01=H 10=B 11=W
// LessIn,ZeroIn    in   1   ALU flags from EX/MA
// ResultIn         in   32  ALU result = memory byte address
// DataIn           in   32  store data (rt)
// PCRelAddrIn      in   32  branch target
// retAddrIn        in   32  link address
// rdIn             in   5   destination register
// memReqOut        out  1   memory request
// memWeOut         out  1   1 = write
// memAddrOut       out  32  {ResultIn[31:2],2'b00}
// memBeOut         out  4   byte enables, little-endian
// memWdataOut      out  32  replicated store data
// memRdataIn       in   32  read data, valid with memAckIn
// memAckIn         in   1   access complete this cycle
// stallOut         out  1   hold PC, IF/ID, ID/EX, EX/MA this cycle
// branchTakenOut   out  1   redirect PC; also drives flush of younger stages
// branchTargetOut  out  32  = PCRelAddrIn
// wbDataOut        out  32  write-back value
// rdOut            out  5   = rdIn
// regWriteOut      out  1   write-back enable
// alignErrOut      out  1   misaligned access this cycle
// busErrOut        out  1   memory timeout this cycle
// BEHAVIOUR
// - All outputs are combinational from inputs + state. While resetIn=1, every output is 0.
//   On the reset edge: state<=IDLE, cnt<=0. Reset mid-WAIT abandons the access with no error.
// - memop = MemRead|MemWrite (both set: treat as write). The all-zero bubble from an EX/MA flush is a no-op.
// - Misaligned: H with addr[0]=1, W with addr[1:0]!=0. Response: alignErrOut=1, no req,
//   regWriteOut=0, no stall.
// - FSM IDLE/WAIT:
//   IDLE: aligned memop -> memReqOut=1. Ack same cycle -> complete, stay IDLE, stallOut=0.
//         No ack -> stallOut=1, next WAIT, cnt<=1.
//   WAIT: memReqOut=1 with addr/we/be/wdata held (inputs frozen by stall). Ack -> complete,
//         stallOut=0, next IDLE, cnt<=0. Otherwise cnt<=cnt+1, stallOut=1.
//         If cnt==TIMEOUT with no ack: busErrOut=1, memReqOut=0, stallOut=0, regWriteOut=0, next IDLE.
//         Ack takes priority over timeout in the same cycle.
// - Store: B -> wdata={4{DataIn[7:0]}}, be=4'b0001<<addr[1:0]; H -> wdata={2{DataIn[15:0]}},
//   be=addr[1]?1100:0011; W -> wdata=DataIn, be=1111.
// - Load: select byte/half by addr, sign-extend to 32; W passes memRdataIn.
// - wbDataOut: Link -> retAddrIn; MemRead -> extended load; else ResultIn.
// - regWriteOut = RegWrite & ~alignErr & ~busErr & (~MemRead | load completing this cycle).
//   A stalled load keeps regWriteOut=0 until ack.
// - branchTakenOut = (BrEq&ZeroIn)|(BrLt&LessIn). Never asserted with a memop (decoder guarantees).
// - One-cycle completion: on an ack/timeout cycle stall drops, so EX/MA loads the next instruction at that edge.
// TESTING
// - Zero-wait word load: addr 0x100, rdata 0x80000001, ack same cycle -> no stall, wbData=0x80000001, regWrite=1.
// - Byte load: addr 0x103, rdata 0x80FF_0000 -> wbData=0xFFFFFF80. Half store: addr 0x102, data 0x1234 ->
//   be=1100, wdata=0x12341234.
// - Ack after 3 cycles: stallOut=1 for 3 cycles, req/addr held, regWrite only on ack cycle.
// - No ack, TIMEOUT=16: stall for 16 cycles, busErrOut on cycle 17, regWrite=0, FSM back in IDLE.
// - Misaligned word at 0x102 -> alignErrOut=1, memReq=0, stall=0. BrLt with LessIn=1 -> taken, target=PCRelAddrIn.
// - resetIn=1 during WAIT -> all outputs 0, next instruction starts fresh from IDLE.

Source files
------------

// File: rtl/ma_stage.sv
// Memory-access stage: resolves conditional branches, runs loads/stores over a
// req/ack data-memory port, and forms the write-back value for the MA/WB register.
// The upstream pipeline is held while an access is outstanding; an access that
// never receives an ack is abandoned with a bus error after TIMEOUT cycles.
module ma_stage #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 8
) (
    input  logic        clkIn,
    input  logic        resetIn,
    input  logic [7:0]  ctrSignalsIn,
    input  logic        LessIn,
    input  logic        ZeroIn,
    input  logic [31:0] ResultIn,
    input  logic [31:0] DataIn,
    input  logic [31:0] PCRelAddrIn,
    input  logic [31:0] retAddrIn,
    input  logic [4:0]  rdIn,
    output logic        memReqOut,
    output logic        memWeOut,
    output logic [31:0] memAddrOut,
    output logic [3:0]  memBeOut,
    output logic [31:0] memWdataOut,
    input  logic [31:0] memRdataIn,
    input  logic        memAckIn,
    output logic        stallOut,
    output logic        branchTakenOut,
    output logic [31:0] branchTargetOut,
    output logic [31:0] wbDataOut,
    output logic [4:0]  rdOut,
    output logic        regWriteOut,
    output logic        alignErrOut,
    output logic        busErrOut
);

    typedef enum logic {IDLE, WAIT} stateT;

    stateT            state, nextState;
    logic [CNT_W-1:0] cnt, nextCnt;

    // Control-word decode
    logic       memRead, memWrite, regWrite, brEq, brLt, link;
    logic [1:0] size;
    assign memRead  = ctrSignalsIn[0];
    assign memWrite = ctrSignalsIn[1];
    assign regWrite = ctrSignalsIn[2];
    assign brEq     = ctrSignalsIn[3];
    assign brLt     = ctrSignalsIn[4];
    assign link     = ctrSignalsIn[5];
    assign size     = ctrSignalsIn[7:6];

    logic sizeByte, sizeHalf, sizeWord;
    assign sizeByte = (size == 2'b10);
    assign sizeHalf = (size == 2'b01);
    assign sizeWord = (size[1] == size[0]);   // 00 and 11 both mean word

    // A request with both MemRead and MemWrite set is a store.
    logic memOp, isLoad, misaligned, accessOk, timedOut;
    assign memOp      = memRead | memWrite;
    assign isLoad     = memRead & ~memWrite;
    assign misaligned = memOp & ((sizeHalf & ResultIn[0]) |
                                 (sizeWord & (ResultIn[1:0] != 2'b00)));
    assign accessOk   = memOp & ~misaligned;
    assign timedOut   = (state == WAIT) && (cnt == CNT_W'(TIMEOUT)) && !memAckIn;

    // Store lane steering and load extraction, little-endian
    logic [7:0]  loadByte;
    logic [15:0] loadHalf;
    logic [31:0] loadExt, storeData;
    logic [3:0]  storeBe;
    assign loadByte  = memRdataIn[{ResultIn[1:0], 3'b000} +: 8];
    assign loadHalf  = ResultIn[1] ? memRdataIn[31:16] : memRdataIn[15:0];
    assign loadExt   = sizeByte ? {{24{loadByte[7]}}, loadByte} :
                       sizeHalf ? {{16{loadHalf[15]}}, loadHalf} : memRdataIn;
    assign storeData = sizeByte ? {4{DataIn[7:0]}} :
                       sizeHalf ? {2{DataIn[15:0]}} : DataIn;
    assign storeBe   = sizeByte ? (4'b0001 << ResultIn[1:0]) :
                       sizeHalf ? (ResultIn[1] ? 4'b1100 : 4'b0011) : 4'b1111;

    // State register: synchronous reset abandons any outstanding access
    always_ff @(posedge clkIn) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (resetIn) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= nextState;
            cnt   <= nextCnt;
        end
    end

    // Next-state: enter WAIT on an unacknowledged access, leave on ack or timeout
    always_comb begin
        // NOTE: defaults first so no path through the block leaves a target
        // unassigned, which would otherwise infer a latch.
        nextState = state;
        nextCnt   = cnt;
        case (state)
            IDLE: begin
                if (accessOk && !memAckIn) begin
                    nextState = WAIT;
                    nextCnt   = CNT_W'(1);
                end
            end
            WAIT: begin
                if (!accessOk || memAckIn || timedOut) begin
                    nextState = IDLE;
                    nextCnt   = '0;
                end else begin
                    nextCnt = cnt + 1'b1;
                end
            end
            default: begin
                nextState = IDLE;
                nextCnt   = '0;
            end
        endcase
    end

    // Outputs: all forced low while reset is held
    always_comb begin
        memReqOut       = 1'b0;
        memWeOut        = 1'b0;
        memAddrOut      = '0;
        memBeOut        = '0;
        memWdataOut     = '0;
        stallOut        = 1'b0;
        branchTakenOut  = 1'b0;
        branchTargetOut = '0;
        wbDataOut       = '0;
        rdOut           = '0;
        regWriteOut     = 1'b0;
        alignErrOut     = 1'b0;
        busErrOut       = 1'b0;
        if (!resetIn) begin
            memReqOut       = accessOk & ~timedOut;
            memWeOut        = memWrite;
            memAddrOut      = {ResultIn[31:2], 2'b00};
            memBeOut        = storeBe;
            memWdataOut     = storeData;
            stallOut        = accessOk & ~timedOut & ~memAckIn;
            branchTakenOut  = (brEq & ZeroIn) | (brLt & LessIn);
            branchTargetOut = PCRelAddrIn;
            rdOut           = rdIn;
            alignErrOut     = misaligned;
            busErrOut       = timedOut;
            regWriteOut     = regWrite & ~misaligned & ~timedOut &
                              (~isLoad | (accessOk & memAckIn));
            wbDataOut       = link   ? retAddrIn :
                              isLoad ? loadExt   : ResultIn;
        end
    end

endmodule
